lcd_spi_tx: RTL and testbench

LCD_SPI_TX -- requirements
Module: lcd_spi_tx

---
 rtl/lcd_spi_tx_if.sv | 19 +
 rtl/lcd_spi_tx.sv | 117 +++++++++++
 tb/tb_lcd_spi_tx.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/lcd_spi_tx_if.sv
// Upstream request bundle for the LCD SPI transmitter:
// a frame request level with its 9-bit payload, and the done pulse back.
interface lcd_spi_tx_if;
  logic       en_write;
  logic [8:0] data;
  logic       wr_done;

  modport master (
    output en_write,
    output data,
    input  wr_done
  );

  modport slave (
    input  en_write,
    input  data,
    output wr_done
  );
endinterface

// File: rtl/lcd_spi_tx.sv
// Mode-0 SPI transmitter for an LCD panel: one 9-bit {dc, byte}
// frame per request, MSB first, followed by a fixed idle gap.
module lcd_spi_tx #(
  parameter int CLK_DIV = 2,
  parameter int GAP_CYC = 3
) (
  input  logic        sys_clk_50MHz,
  input  logic        sys_rst,
  lcd_spi_tx_if.slave req,
  output logic        lcd_cs,
  output logic        lcd_dc,
  output logic        lcd_sck,
  output logic        lcd_mosi
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    SHIFT_HI = 3'd2,
    SHIFT_LO = 3'd3,
    END      = 3'd4,
    GAP      = 3'd5
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);

  state_t     state;
  logic [7:0] div_cnt;
  logic [2:0] bit_cnt;
  logic [6:0] sr;
  logic       wr_done_q;

  assign req.wr_done = wr_done_q;

  wire div_last = (div_cnt == DIV_LAST);

  always_ff @(posedge sys_clk_50MHz or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      sr        <= '0;
      lcd_cs    <= 1'b1;
      lcd_dc    <= 1'b0;
      lcd_sck   <= 1'b0;
      lcd_mosi  <= 1'b0;
      wr_done_q <= 1'b0;
    end else begin
      div_cnt <= div_cnt + 8'd1;
      case (state)
        IDLE: begin
          div_cnt   <= '0;
          lcd_cs    <= 1'b1;
          lcd_sck   <= 1'b0;
          lcd_mosi  <= 1'b0;
          wr_done_q <= 1'b0;
          if (req.en_write) begin
            sr       <= req.data[6:0];
            bit_cnt  <= 3'd7;
            lcd_cs   <= 1'b0;
            lcd_dc   <= req.data[8];
            lcd_mosi <= req.data[7];
            state    <= SETUP;
          end
        end
        SETUP, SHIFT_LO: begin
          if (div_last) begin
            div_cnt <= '0;
            lcd_sck <= 1'b1;
            state   <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          if (div_last) begin
            div_cnt <= '0;
            lcd_sck <= 1'b0;
            if (bit_cnt == 3'd0) begin
              state <= END;
            end else begin
              // next bit goes out on the falling edge
              lcd_mosi <= sr[6];
              sr       <= {sr[5:0], 1'b0};
              bit_cnt  <= bit_cnt - 3'd1;
              state    <= SHIFT_LO;
            end
          end
        end
        END: begin
          if (div_last) begin
            div_cnt   <= '0;
            lcd_cs    <= 1'b1;
            lcd_mosi  <= 1'b0;
            wr_done_q <= 1'b1;
            state     <= GAP;
          end
        end
        GAP: begin
          wr_done_q <= 1'b0;
          if (div_cnt == GAP_LAST) begin
            div_cnt <= '0;
            state   <= IDLE;
          end
        end
        default: begin
          div_cnt   <= '0;
          lcd_cs    <= 1'b1;
          lcd_sck   <= 1'b0;
          lcd_mosi  <= 1'b0;
          wr_done_q <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_spi_tx.sv
// Directed plus randomized bench for lcd_spi_tx at CLK_DIV=2 and
// CLK_DIV=1, checked against frame-level timing and bit-order rules.
module tb_lcd_spi_tx;

  localparam int DIV = 2;
  localparam int GAP = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd_spi_tx_if if0 ();
  lcd_spi_tx_if if1 ();

  logic cs0, dc0, sck0, mosi0;
  logic cs1, dc1, sck1, mosi1;

  lcd_spi_tx #(.CLK_DIV(DIV), .GAP_CYC(GAP)) dut (
    .sys_clk_50MHz(clk),
    .sys_rst      (rst),
    .req          (if0),
    .lcd_cs       (cs0),
    .lcd_dc       (dc0),
    .lcd_sck      (sck0),
    .lcd_mosi     (mosi0)
  );

  lcd_spi_tx #(.CLK_DIV(1), .GAP_CYC(GAP)) dut1 (
    .sys_clk_50MHz(clk),
    .sys_rst      (rst),
    .req          (if1),
    .lcd_cs       (cs1),
    .lcd_dc       (dc1),
    .lcd_sck      (sck1),
    .lcd_mosi     (mosi1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int sel   = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // {cs, dc, sck, mosi, wr_done} of the selected instance
  function automatic logic [4:0] pins();
    if (sel == 1) return {cs1, dc1, sck1, mosi1, if1.wr_done};
    return {cs0, dc0, sck0, mosi0, if0.wr_done};
  endfunction

  task automatic drive(input logic en, input logic [8:0] d);
    if (sel == 1) begin
      if1.en_write = en;
      if1.data     = d;
    end else begin
      if0.en_write = en;
      if0.data     = d;
    end
  endtask

  // Send one frame from idle; checks timing, bits, dc and the gap.
  task automatic frame(input logic [8:0] d, input int div,
                       input int drop_at, input logic [8:0] d_after);
    int n, rises, lowcnt, done_at, done_cnt, last_rise;
    logic [7:0] got;
    logic [4:0] p, prev;
    logic stable, spacing, hold_mosi;
    drive(1'b1, d);
    @(negedge clk);
    p = pins();
    chk("capture_cs", 32'(p[4]), 0);
    chk("capture_dc", 32'(p[3]), 32'(d[8]));
    n = 0; rises = 0; lowcnt = 0; done_at = -1; done_cnt = 0;
    last_rise = 0; got = '0; stable = 1'b1; spacing = 1'b1;
    hold_mosi = 1'b0; prev = p;
    if (p[4] == 1'b0) lowcnt++;
    if (drop_at == 0) drive(1'b0, d_after);
    while (n < 17 * div + GAP + 4) begin
      @(negedge clk);
      n++;
      p = pins();
      if (n == drop_at) drive(1'b0, d_after);
      if (p[4] == 1'b0) lowcnt++;
      if (p[2] && !prev[2]) begin
        if (rises == 0) begin
          if (n != div) spacing = 1'b0;
        end else if (n - last_rise != 2 * div) begin
          spacing = 1'b0;
        end
        rises++;
        last_rise = n;
        got = {got[6:0], p[1]};
        hold_mosi = p[1];
      end else if (p[2] && p[1] !== hold_mosi) begin
        stable = 1'b0;
      end
      if (p[0]) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      prev = p;
    end
    chk("wr_done_at", 32'(done_at), 32'(17 * div));
    chk("wr_done_pulses", 32'(done_cnt), 1);
    chk("cs_low_cycles", 32'(lowcnt), 32'(17 * div));
    chk("sck_rises", 32'(rises), 8);
    chk("sck_spacing", 32'(spacing), 1);
    chk("frame_byte", 32'(got), 32'(d[7:0]));
    chk("mosi_stable_hi", 32'(stable), 1);
    chk("idle_after", 32'(p), 32'({1'b1, d[8], 3'b000}));
  endtask

  logic [4:0] p;
  logic [8:0] d;
  int rises, ncap, last, prev_cs, prevs, bad_done, bad_cs;

  initial begin
    if0.en_write = 1'b0; if0.data = '0;
    if1.en_write = 1'b0; if1.data = '0;
    repeat (2) @(negedge clk);
    sel = 0; chk("reset_pins0", 32'(pins()), 32'(5'b10000));
    sel = 1; chk("reset_pins1", 32'(pins()), 32'(5'b10000));
    rst = 1'b0;
    sel = 0;
    repeat (3) @(negedge clk);
    chk("idle_no_capture", 32'(pins()), 32'(5'b10000));

    // basic command byte
    frame(9'h0CF, DIV, 0, 9'h0CF);

    // command/command/data sequence
    frame(9'h029, DIV, 0, 9'h029);
    frame(9'h036, DIV, 0, 9'h036);
    frame(9'h108, DIV, 0, 9'h108);

    // request held high: periodic frames, sck idle between them
    drive(1'b1, 9'h1A5);
    ncap = 0; last = -1; prev_cs = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      p = pins();
      if (!p[4] && prev_cs == 1) begin
        if (last >= 0) chk("cont_period", 32'(i - last), 32'(17 * DIV + GAP + 1));
        last = i;
        ncap++;
      end
      if (p[4]) chk("cont_sck_idle", 32'(p[2]), 0);
      prev_cs = int'(p[4]);
    end
    chk("cont_frames", 32'(ncap), 6);
    drive(1'b0, 9'h1A5);
    repeat (40) @(negedge clk);
    chk("cont_idle_end", 32'(pins()), 32'(5'b11000));

    // reset during the 4th bit high phase
    drive(1'b1, 9'h1B3);
    rises = 0; prevs = 0;
    for (int i = 0; i < 60 && rises < 4; i++) begin
      @(negedge clk);
      p = pins();
      if (p[2] && prevs == 0) rises++;
      prevs = int'(p[2]);
    end
    chk("rst_reach_bit4", 32'(rises), 4);
    drive(1'b0, 9'h1B3);
    #2 rst = 1'b1;
    #1 chk("rst_async_pins", 32'(pins()), 32'(5'b10000));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bad_done = 0; bad_cs = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      p = pins();
      if (p[0]) bad_done++;
      if (!p[4]) bad_cs++;
    end
    chk("rst_no_done", 32'(bad_done), 0);
    chk("rst_no_capture", 32'(bad_cs), 0);
    frame(9'h1B3, DIV, 0, 9'h1B3);

    // fastest divider
    sel = 1;
    frame(9'h1FF, 1, 0, 9'h1FF);

    // request drop and data change mid-frame
    sel = 0;
    frame(9'h155, DIV, 2, 9'h000);

    // randomized frames on both instances
    for (int k = 0; k < 10; k++) begin
      sel = k % 2;
      d = 9'($urandom_range(0, 511));
      frame(d, (sel == 1) ? 1 : DIV, int'($urandom_range(0, 10)),
            9'($urandom_range(0, 511)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
